// File: rtl/config_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : config_serial_tx
// Purpose  : Three-wire (sen/sclk/sdata) transmitter for the Mandelbrot
//            engine's configuration shift register. Sends a WIDTH-bit word
//            LSB-first, one bit per sclk rising edge, with every sclk phase
//            lasting HALF_PERIOD clk cycles so that the receiver's 3-flop
//            input synchronizers see clean edges. sen falling is the
//            receiver's "start render" event.
// Ports    : clk            - system clock, rising edge
//            combined_rst_n - asynchronous active-low reset
//            start          - transfer request, honoured only when idle
//            data           - configuration word, captured on acceptance
//            busy           - transfer in progress (mirrors sen)
//            done           - one-cycle pulse coincident with sen falling
//            sen/sdata/sclk - serial link outputs, all registered
// Revision : 1.0 - initial release
// ============================================================================
module config_serial_tx #(
  parameter int WIDTH       = 57,
  parameter int HALF_PERIOD = 4
) (
  input  logic             clk,
  input  logic             combined_rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic             sen,
  output logic             sdata,
  output logic             sclk
);

  localparam int PH_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [PH_W-1:0]  PH_MAX   = PH_W'(HALF_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    TRAIL = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic               sen_q, sen_d;
  logic               sclk_q, sclk_d;
  logic               sdata_q, sdata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Shift register advanced by one position; bit 0 is the next bit to send.
  logic [WIDTH-1:0]   shift_nxt;
  assign shift_nxt = shift_q >> 1;

  always_ff @(posedge clk or negedge combined_rst_n) begin
    if (!combined_rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      sen_q   <= 1'b0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      sen_q   <= sen_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    sen_d   = sen_q;
    sclk_d  = sclk_q;
    sdata_d = sdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q == IDLE) begin
      // Outputs are loaded directly on the accepting edge so that a start
      // held high re-enters the link with sen low for a single cycle.
      if (start) begin
        shift_d = data;
        sen_d   = 1'b1;
        sclk_d  = 1'b0;
        sdata_d = data[0];
        busy_d  = 1'b1;
        phase_d = PH_MAX;
        idx_d   = '0;
        state_d = LEAD;
      end
    end else if (phase_q != '0) begin
      phase_d = phase_q - PH_W'(1);
    end else begin
      // End of a HALF_PERIOD-long phase: every state transition happens here.
      phase_d = PH_MAX;
      case (state_q)
        LEAD: begin
          sclk_d  = 1'b1;
          state_d = HIGH;
        end
        HIGH: begin
          sclk_d = 1'b0;
          if (idx_q != IDX_LAST) begin
            // Data only moves on the sclk falling edge, centring each bit
            // around the next rising edge.
            idx_d   = idx_q + IDX_W'(1);
            shift_d = shift_nxt;
            sdata_d = shift_nxt[0];
            state_d = LOW;
          end else begin
            state_d = TRAIL;
          end
        end
        LOW: begin
          sclk_d  = 1'b1;
          state_d = HIGH;
        end
        TRAIL: begin
          sen_d   = 1'b0;
          sdata_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sen   = sen_q;
  assign sdata = sdata_q;
  assign sclk  = sclk_q;

endmodule
`default_nettype wire

// File: tb/tb_config_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_config_serial_tx
// Purpose  : Self-checking bench for config_serial_tx. Three instances cover
//            the default (57/4) and the edge (1/2, 8/3) parameter sets. The
//            expected link waveform is computed in closed form from the
//            transfer timing; a synchronizing receiver model checks the
//            word and render event seen by the far end.
// Revision : 1.0 - initial release
// ============================================================================
module tb_config_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        combined_rst_n;
  logic        start_a, start_b, start_c;
  logic [56:0] data_a;
  logic [0:0]  data_b;
  logic [7:0]  data_c;
  logic        busy_a, done_a, sen_a, sdata_a, sclk_a;
  logic        busy_b, done_b, sen_b, sdata_b, sclk_b;
  logic        busy_c, done_c, sen_c, sdata_c, sclk_c;

  int errors = 0;
  int checks = 0;

  config_serial_tx #(.WIDTH(57), .HALF_PERIOD(4)) u_dut_a (
    .clk(clk), .combined_rst_n(combined_rst_n), .start(start_a), .data(data_a),
    .busy(busy_a), .done(done_a), .sen(sen_a), .sdata(sdata_a), .sclk(sclk_a));

  config_serial_tx #(.WIDTH(1), .HALF_PERIOD(2)) u_dut_b (
    .clk(clk), .combined_rst_n(combined_rst_n), .start(start_b), .data(data_b),
    .busy(busy_b), .done(done_b), .sen(sen_b), .sdata(sdata_b), .sclk(sclk_b));

  config_serial_tx #(.WIDTH(8), .HALF_PERIOD(3)) u_dut_c (
    .clk(clk), .combined_rst_n(combined_rst_n), .start(start_c), .data(data_c),
    .busy(busy_c), .done(done_c), .sen(sen_c), .sdata(sdata_c), .sclk(sclk_c));

  // Far-end receiver: 3-flop synchronizer, right shift on synced sclk rise,
  // render start counted on synced sen fall.
  logic [2:0]  rx_s1 = '0, rx_s2 = '0, rx_s3 = '0, rx_s4 = '0;
  logic [56:0] rx_word = '0;
  int          rx_renders = 0;
  always @(posedge clk) begin
    rx_s1 <= {sen_a, sclk_a, sdata_a};
    rx_s2 <= rx_s1;
    rx_s3 <= rx_s2;
    rx_s4 <= rx_s3;
    if (rx_s3[1] && !rx_s4[1]) rx_word <= {rx_s3[0], rx_word[56:1]};
    if (!rx_s3[2] && rx_s4[2]) rx_renders <= rx_renders + 1;
  end

  function automatic int p_w(input int sel);
    return (sel == 0) ? 57 : (sel == 1) ? 1 : 8;
  endfunction

  function automatic int p_h(input int sel);
    return (sel == 0) ? 4 : (sel == 1) ? 2 : 3;
  endfunction

  // {sen, sclk, sdata, busy, done}
  function automatic logic [4:0] get_out(input int sel);
    case (sel)
      0:       return {sen_a, sclk_a, sdata_a, busy_a, done_a};
      1:       return {sen_b, sclk_b, sdata_b, busy_b, done_b};
      default: return {sen_c, sclk_c, sdata_c, busy_c, done_c};
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic set_data(input int sel, input logic [63:0] d);
    case (sel)
      0:       data_a = d[56:0];
      1:       data_b = d[0:0];
      default: data_c = d[7:0];
    endcase
  endtask

  // Expected outputs o clk edges after the accepting edge (o=0 is just after
  // it). The link spends H cycles in each of 2W+1 half-periods: lead-in,
  // then alternating high/low with bit k driven from the fall before rise k.
  function automatic logic [4:0] model(input int w, input int h,
                                       input logic [63:0] d, input int o);
    int   p;
    int   k;
    int   span;
    logic e_sen, e_sclk, e_sd, e_done;
    p      = o / h;
    span   = (2 * w + 1) * h;
    e_sen  = (o < span);
    e_sclk = e_sen && (p % 2 == 1);
    k      = p / 2;
    if (k > w - 1) k = w - 1;
    e_sd   = e_sen ? d[k] : 1'b0;
    e_done = (o == span);
    return {e_sen, e_sclk, e_sd, e_sen, e_done};
  endfunction

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Runs n transfers on instance sel starting with word d0, checking every
  // cycle against the model. hold keeps start high (back-to-back, data
  // randomly all-zeros/all-ones each cycle); ign pulses start at 50 and 200
  // cycles into the transfer; abort_at >= 0 resets the design at that cycle.
  task automatic run(input int sel, input int n, input bit hold, input bit ign,
                     input logic [63:0] d0, input int abort_at);
    int          w, h, tp, idx, o, rises;
    logic [63:0] acc[$];
    logic [63:0] cur, bits, msk;
    logic [4:0]  got, exp;
    logic        prev_sclk;
    w = p_w(sel);
    h = p_h(sel);
    tp = (2 * w + 1) * h + 1;
    msk = (64'd1 << w) - 64'd1;
    rises = 0;
    bits = '0;
    prev_sclk = 1'b0;
    cur = d0;
    set_data(sel, cur);
    set_start(sel, 1'b1);
    acc.push_back(cur);
    @(posedge clk); #1;
    for (int t = 0; t < n * tp + 2; t++) begin
      idx = t / tp;
      o   = t % tp;
      exp = (idx < n) ? model(w, h, acc[idx], o) : 5'b0;
      got = get_out(sel);
      check($sformatf("wave[s%0d,x%0d,o%0d]", sel, idx, o), 64'(got), 64'(exp));
      if (got[3] && !prev_sclk) begin
        bits[rises] = got[2];
        rises++;
      end
      prev_sclk = got[3];
      if (idx < n && o == tp - 1) begin
        check($sformatf("rises[s%0d,x%0d]", sel, idx), 64'(rises), 64'(w));
        check($sformatf("bits[s%0d,x%0d]", sel, idx), bits & msk, acc[idx] & msk);
        rises = 0;
        bits = '0;
      end
      if (t == abort_at) begin
        set_start(sel, 1'b0);
        #2 combined_rst_n = 1'b0;
        #1 check("abort_async", 64'(get_out(sel)), 64'd0);
        for (int i = 0; i < 2; i++) begin
          @(posedge clk); #1;
          check("abort_held", 64'(get_out(sel)), 64'd0);
        end
        combined_rst_n = 1'b1;
        return;
      end
      if (hold) begin
        cur = ($urandom_range(0, 1) == 1) ? '1 : '0;
        set_data(sel, cur);
        if (o == tp - 1 && idx + 1 < n) acc.push_back(cur);
        if (t == n * tp - 1) set_start(sel, 1'b0);
      end else begin
        set_data(sel, {$urandom, $urandom});
        if (t == 0) set_start(sel, 1'b0);
        if (ign && (o == 50 || o == 200)) set_start(sel, 1'b1);
        if (ign && (o == 51 || o == 201)) set_start(sel, 1'b0);
      end
      @(posedge clk); #1;
    end
  endtask

  int renders_before;

  initial begin
    combined_rst_n = 1'b0;
    start_a = 1'b1;
    start_b = 1'b0;
    start_c = 1'b0;
    data_a  = '0;
    data_b  = '0;
    data_c  = '0;

    // Reset held with start asserted: everything stays quiet.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      for (int s = 0; s < 3; s++)
        check($sformatf("reset[s%0d,c%0d]", s, i), 64'(get_out(s)), 64'd0);
    end
    combined_rst_n = 1'b1;

    // Default transfer, accepted on the first edge after release.
    renders_before = rx_renders;
    run(0, 1, 1'b0, 1'b0, 64'h0123456789ABCDE, -1);
    repeat (4) @(posedge clk);
    #1;
    check("rx_word", 64'(rx_word), 64'h0123456789ABCDE);
    check("rx_renders", 64'(rx_renders - renders_before), 64'd1);

    // Edge parameter sets.
    run(1, 1, 1'b0, 1'b0, 64'd1, -1);
    run(1, 1, 1'b0, 1'b0, 64'd0, -1);
    run(2, 1, 1'b0, 1'b0, 64'hA5, -1);
    run(2, 1, 1'b0, 1'b0, {$urandom, $urandom}, -1);
    run(2, 2, 1'b1, 1'b0, '1, -1);

    // Start pulses during a transfer are ignored; data churns meanwhile.
    run(0, 1, 1'b0, 1'b1, {$urandom, $urandom}, -1);

    // Back-to-back with start held high.
    run(0, 3, 1'b1, 1'b0, '0, -1);

    // Reset 100 cycles into a transfer, then a clean transfer after release.
    run(0, 1, 1'b0, 1'b0, {$urandom, $urandom}, 100);
    run(0, 1, 1'b0, 1'b0, {$urandom, $urandom}, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/config_serial_tx.md
# config_serial_tx

Serial transmitter for the three-wire configuration link (sen/sclk/sdata) that loads the Mandelbrot engine's configuration shift register and triggers rendering. It serializes a parallel configuration word LSB-first, at a clk-derived bit rate slow enough for the receiver's 3-flop input synchronizers. A falling sen is the receiver's "start render" event. The block sits on the driving side of ui_in[2:0]: in the on-chip zoom/demo sequencer, and as the bus-functional driver in the system bench.

## Interface
- WIDTH, 57: configuration word length in bits; range 1..64.
- HALF_PERIOD, 4: clk cycles per sclk phase; minimum 2, which the receiver synchronizer needs.
- clk  input  1  system clock, rising-edge.
- combined_rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request a transfer; sampled only in IDLE.
- data  input  WIDTH  configuration word; captured on the accepting edge.
- busy  output  1  high from the cycle after acceptance until sen falls.
- done  output  1  one-cycle pulse, coincident with sen falling.
- sen  output  1  serial enable, to ui_in[0].
- sdata  output  1  serial data, to ui_in[1].
- sclk  output  1  serial clock, to ui_in[2]; the receiver samples on its rising edge.

## Operation
- Reset is decided as follows: reset combined_rst_n, asynchronous, active-low; clock clk.
- Reset values are sen=0, sclk=0, sdata=0, busy=0, done=0, state IDLE, counters 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States are IDLE, LEAD, HIGH, LOW and TRAIL.
- A phase counter counts HALF_PERIOD-1 down to 0, width $clog2(HALF_PERIOD). A bit index counts 0..WIDTH-1, width $clog2(WIDTH) with a minimum of 1. The shift register is WIDTH bits.
- IDLE: when start=1, latch data into the shift register. Next cycle: sen=1, sclk=0, sdata=data[0], busy=1, go to LEAD.
- LEAD: hold for HALF_PERIOD cycles, then sclk=1 and go to HIGH.
- HIGH: hold for HALF_PERIOD cycles, then sclk=0.
  - If the bit index is below WIDTH-1: increment it, drive sdata with the next bit (LSB-first shift), go to LOW.
  - Otherwise hold sdata and go to TRAIL.
- LOW: hold for HALF_PERIOD cycles, then sclk=1 and go to HIGH.
- TRAIL: hold for HALF_PERIOD cycles, then sen=0, sdata=0, busy=0, done=1, go to IDLE.
- done clears the following cycle.
- sdata changes only together with a sclk falling edge, or at the LEAD entry. This gives HALF_PERIOD cycles of setup and hold around every rising edge.
- Exactly WIDTH rising sclk edges occur per transfer, all while sen=1. sclk is 0 whenever sen changes.
- Bit k of data is sent as the k-th rising edge (k=0 first). After the transfer, the receiver's right-shifting register therefore holds data in natural order.
- start while busy=1 is ignored, and no request is queued. Changing data while busy has no effect.
- A start held high continuously produces back-to-back transfers: a new acceptance in the cycle done=1, then sen rises again one cycle later. sen is low for exactly one cycle.
- Reset mid-transfer forces all outputs to 0 at once. The receiver may see that sen fall as a render start, so the system resets both ends together.

## Timing
- Start accepted at edge 0 gives sen=1 from cycle 1.
- sclk first rises at cycle 1+H.
- The k-th rising edge (k=0..WIDTH-1) is at cycle 1+H+2kH.
- sen falls and done=1 at cycle T=1+(2*WIDTH+1)*H.
- Default transfer (WIDTH=57, H=4): first sclk rise at cycle 5, last at cycle 453, sen falls at cycle 461.
- Throughput: one transfer per T cycles, plus a minimum one-cycle gap.
- Receiver-visible latency is +3 clk for its synchronizer. This does not affect this block.

## Test plan
- Reset: hold combined_rst_n=0 for 5 cycles with start=1. Required: all outputs 0. After release, busy=1 is seen on the second edge.
- Default transfer, data=57'h0123456789ABCDE: sen high for exactly 460 cycles, exactly 57 sclk rises. The bits sampled at the rises, LSB-first, reconstruct the data. done is a single pulse at cycle 461. A behavioral receiver model (3-flop sync plus shift) ends with the exact data and flags one render start.
- Edge parameters: WIDTH=1, H=2 gives T=7 and one sclk rise at cycle 3. WIDTH=8, H=3, data=8'hA5 gives the bit sequence 1,0,1,0,0,1,0,1.
- Ignored start: pulse start at cycles 50 and 200 of a transfer. Required: no waveform change, and exactly one done pulse.
- Back-to-back: start held high, data toggled between 57'h0 and all-ones. Required: sen low for exactly 1 cycle between transfers, and each transfer carries the data value present at its acceptance edge.
- Mid-transfer reset at cycle 100: outputs 0 within the same cycle (asynchronous), no done pulse. A start after release gives a complete, correct transfer.
